// File: rtl/disp_arb_pkg.sv
// disp_arb_pkg: shared types and the round-robin search helper for the
// display arbiter and any other display/debug arbiter built on rr_picker.
package disp_arb_pkg;

    localparam int NREQ_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } rr_pick_t;

    // First requester searching upward from ptr+1 with wrap at n, skipping
    // any source flagged in exclude.
    function automatic rr_pick_t next_rr(input logic [NREQ_MAX-1:0] req,
                                         input logic [1:0]          ptr,
                                         input logic [NREQ_MAX-1:0] exclude,
                                         input int                  n);
        rr_pick_t res;
        int       cand;
        res.found = 1'b0;
        res.idx   = 2'd0;
        for (int i = 1; i <= NREQ_MAX; i++) begin
            cand = int'(ptr) + i;
            if (cand >= n) cand = cand - n;
            if ((i <= n) && !res.found && req[cand[1:0]] && !exclude[cand[1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/disp_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selection starting after ptr.
module rr_picker
    import disp_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    input  logic [NREQ-1:0] exclude,
    output logic            found,
    output logic [1:0]      idx
);

    logic [NREQ_MAX-1:0] req_ext;
    logic [NREQ_MAX-1:0] excl_ext;
    rr_pick_t            pick;

    // Widen to the package width and run the shared search.
    always_comb begin
        req_ext                = '0;
        excl_ext               = '0;
        req_ext[NREQ-1:0]      = req;
        excl_ext[NREQ-1:0]     = exclude;
        pick                   = next_rr(req_ext, ptr, excl_ext, NREQ);
    end

    assign found = pick.found;
    assign idx   = pick.idx;

endmodule

// File: rtl/disp_arbiter.sv
// disp_arbiter: round-robin time sharing of the seven-segment display word
// among up to four sources, with a minimum dwell per owner and a lock input.
// Optional DISP_ARB_BLANK_EN inserts a dark GAP of BLANK_CYCLES between owners.
//
// state | meaning
// IDLE  | no owner, display dark
// SHOW  | owner granted, digit tracks its data word
// GAP   | dark interval before handing over to the latched target
module disp_arbiter
    import disp_arb_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int DWELL        = 100_000_000,
    parameter int BLANK_CYCLES = 10_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   data,
    input  logic                 lock,
    output logic [NREQ-1:0]      grant,
    output logic [1:0]           owner,
    output logic [31:0]          digit,
    output logic                 blank
);

    localparam int             CW           = $clog2(DWELL);
    localparam logic [CW-1:0]  DWELL_RELOAD = CW'(DWELL - 1);
    localparam logic [1:0]     PTR_RESET    = 2'(NREQ - 1);

    if ((NREQ < 2) || (NREQ > NREQ_MAX) || (DWELL < 2) || (BLANK_CYCLES < 1)) begin : g_bad_param
        $error("disp_arbiter: parameter out of range");
    end

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          owner_q, owner_d;
    logic [31:0]         digit_q, digit_d;

`ifdef DISP_ARB_BLANK_EN
    localparam int             GW         = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [GW-1:0]  GAP_RELOAD = GW'(BLANK_CYCLES - 1);
    logic [GW-1:0]       gcnt_q, gcnt_d;
    logic [1:0]          target_q, target_d;
`endif

    logic [31:0]         words [NREQ_MAX];
    logic [NREQ_MAX-1:0] req_ext;
    logic [NREQ_MAX-1:0] excl_ext;
    logic [NREQ_MAX-1:0] grant_ext;
    logic                pick_found;
    logic [1:0]          pick_idx;
    logic                do_switch;
    logic                enter_show;
    logic [1:0]          show_idx;

    for (genvar g = 0; g < NREQ_MAX; g++) begin : g_words
        if (g < NREQ) begin : g_live
            assign words[g] = data[32*g +: 32];
        end else begin : g_tie
            assign words[g] = '0;
        end
    end

    // Request vector widened so 2-bit indices are always in range; the
    // current owner is excluded from the search only while it is showing.
    always_comb begin
        req_ext           = '0;
        req_ext[NREQ-1:0] = req;
        excl_ext          = '0;
        if (state_q == ST_SHOW) excl_ext[owner_q] = 1'b1;
    end

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req     (req),
        .ptr     (ptr_q),
        .exclude (excl_ext[NREQ-1:0]),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    // Next-state logic: arbitration, dwell countdown and digit capture.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        digit_d    = digit_q;
        do_switch  = 1'b0;
        enter_show = 1'b0;
        show_idx   = pick_idx;
`ifdef DISP_ARB_BLANK_EN
        gcnt_d     = gcnt_q;
        target_d   = target_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found) enter_show = 1'b1;
            end
            ST_SHOW: begin
                digit_d = words[owner_q];
                if (!req_ext[owner_q]) begin
                    // Owner left: wins over expiry and ignores lock.
                    if (pick_found) begin
                        do_switch = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        digit_d = digit_q;
                    end
                end else if (!lock) begin
                    if (cnt_q == '0) begin
                        if (pick_found) do_switch = 1'b1;
                        else            cnt_d     = DWELL_RELOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
`ifdef DISP_ARB_BLANK_EN
            ST_GAP: begin
                if (gcnt_q != '0) begin
                    gcnt_d = gcnt_q - 1'b1;
                end else if (req_ext[target_q]) begin
                    enter_show = 1'b1;
                    show_idx   = target_q;
                end else if (pick_found) begin
                    enter_show = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (do_switch) begin
`ifdef DISP_ARB_BLANK_EN
            state_d  = ST_GAP;
            target_d = pick_idx;
            gcnt_d   = GAP_RELOAD;
            cnt_d    = '0;
            digit_d  = digit_q;
`else
            enter_show = 1'b1;
`endif
        end

        if (enter_show) begin
            state_d = ST_SHOW;
            owner_d = show_idx;
            ptr_d   = show_idx;
            cnt_d   = DWELL_RELOAD;
            digit_d = words[show_idx];
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= PTR_RESET;
            cnt_q    <= '0;
            owner_q  <= 2'd0;
            digit_q  <= 32'h0;
`ifdef DISP_ARB_BLANK_EN
            gcnt_q   <= '0;
            target_q <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            digit_q  <= digit_d;
`ifdef DISP_ARB_BLANK_EN
            gcnt_q   <= gcnt_d;
            target_q <= target_d;
`endif
        end
    end

    // Outputs decode directly from registered state so they clear with reset.
    always_comb begin
        grant_ext = '0;
        if (state_q == ST_SHOW) grant_ext[owner_q] = 1'b1;
    end

    assign grant = grant_ext[NREQ-1:0];
    assign owner = (state_q == ST_SHOW) ? owner_q : 2'd0;
    assign digit = digit_q;
`ifdef DISP_ARB_BLANK_EN
    assign blank = (state_q != ST_SHOW);
`else
    assign blank = (state_q == ST_IDLE);
`endif

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: directed vectors for disp_arbiter with DWELL=4,
// BLANK_CYCLES=2, NREQ=4. Owner changes expect a 2-cycle dark gap when
// DISP_ARB_BLANK_EN is defined.
module tb_disp_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         lock;
    logic [3:0]   req;
    logic [127:0] data;
    logic [3:0]   grant;
    logic [1:0]   owner;
    logic [31:0]  digit;
    logic         blank;
    logic [31:0]  w [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb data = {w[3], w[2], w[1], w[0]};

    disp_arbiter #(.NREQ(4), .DWELL(4), .BLANK_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .data  (data),
        .lock  (lock),
        .grant (grant),
        .owner (owner),
        .digit (digit),
        .blank (blank)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_show(input string tag, input logic [1:0] o, input logic [31:0] d);
        chk({tag, ".grant"}, 32'(grant), 32'(1) << o);
        chk({tag, ".owner"}, 32'(owner), 32'(o));
        chk({tag, ".blank"}, 32'(blank), 32'd0);
        chk({tag, ".digit"}, digit, d);
    endtask

    task automatic exp_dark(input string tag, input logic [31:0] d);
        chk({tag, ".grant"}, 32'(grant), 32'd0);
        chk({tag, ".owner"}, 32'(owner), 32'd0);
        chk({tag, ".blank"}, 32'(blank), 32'd1);
        chk({tag, ".digit"}, digit, d);
    endtask

    // Owner change: optional dark gap holding the previous digit, then new owner.
    task automatic rot(input string tag, input logic [1:0] o, input logic [31:0] d_prev);
`ifdef DISP_ARB_BLANK_EN
        repeat (2) begin
            tick();
            exp_dark({tag, ".gap"}, d_prev);
        end
`endif
        tick();
        exp_show(tag, o, w[o]);
    endtask

    initial begin
        w[0] = 32'hC0DE_0000;
        w[1] = 32'hC0DE_0001;
        w[2] = 32'hC0DE_0002;
        w[3] = 32'hC0DE_0003;
        reset = 1'b0;
        req   = 4'b1111;
        lock  = 1'b0;

        repeat (3) tick();
        exp_dark("rst", 32'h0);

        reset = 1'b1;
        tick();
        exp_show("first", 2'd0, w[0]);

        req = 4'b0101;
        repeat (3) begin
            tick();
            exp_show("dwell0", 2'd0, w[0]);
        end
        rot("rot02", 2'd2, w[0]);

        w[2] = 32'hBEEF_0002;
        #1;
        chk("lag", digit, 32'hC0DE_0002);
        tick();
        exp_show("live", 2'd2, 32'hBEEF_0002);
        repeat (2) begin
            tick();
            exp_show("dwell2", 2'd2, 32'hBEEF_0002);
        end
        rot("rot20", 2'd0, 32'hBEEF_0002);

        tick();
        exp_show("d0", 2'd0, w[0]);
        req = 4'b0010;
        rot("drop", 2'd1, w[0]);

        req = 4'b0000;
        tick();
        exp_dark("idle", w[1]);
        tick();
        exp_dark("idle_hold", w[1]);

        req = 4'b0011;
        tick();
        exp_show("lk_grant", 2'd0, w[0]);
        lock = 1'b1;
        repeat (10) begin
            tick();
            exp_show("locked", 2'd0, w[0]);
        end
        lock = 1'b0;
        repeat (3) begin
            tick();
            exp_show("lk_rem", 2'd0, w[0]);
        end
        rot("lk_rot", 2'd1, w[0]);

        req = 4'b0010;
        repeat (8) begin
            tick();
            exp_show("stay", 2'd1, w[1]);
        end

        req   = 4'b1111;
        reset = 1'b0;
        #1;
        exp_dark("async", 32'h0);
        tick();
        exp_dark("rst_hold", 32'h0);
        reset = 1'b1;
        tick();
        exp_show("restart", 2'd0, w[0]);

        req = 4'b0001;
        repeat (3) begin
            tick();
            exp_show("solo", 2'd0, w[0]);
        end
        req = 4'b0000;
        tick();
        exp_dark("expdrop", w[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
